// File: rtl/sw_pkg.sv
// Shared types and constants for the single-wire half-duplex responder.
package sw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    TURN,
    TX_START,
    TX_DATA,
    TX_STOP
  } sw_state_t;

  localparam logic        PIN_RELEASE = 1'b1;
  localparam logic        PIN_DRIVE   = 1'b0;
  localparam int unsigned FRAME_BITS  = 8;

endpackage

// File: rtl/sw_half_duplex_responder_if.sv
// User-side bundle: received byte reporting and the response-byte handshake.
interface sw_half_duplex_responder_if;
  import sw_pkg::*;

  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_err;
  logic [FRAME_BITS-1:0] resp_data;
  logic                  resp_valid;
  logic                  resp_ready;

  modport master (
    output resp_data, resp_valid,
    input  resp_ready, rx_data, rx_valid, rx_err
  );

  modport slave (
    input  resp_data, resp_valid,
    output resp_ready, rx_data, rx_valid, rx_err
  );

endinterface

// File: rtl/sw_bit_timer.sv
// Loadable down-counter; done pulses for one cycle when a loaded count expires.
module sw_bit_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         active_q, active_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      cnt_d    = load_val;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) active_d = 1'b0;
      else             cnt_d    = cnt_q - W'(1);
    end
  end

  assign done = active_q && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/sw_half_duplex_responder.sv
// Responder end of the single-wire link: receive one frame, turn the line
// around, answer with the held response byte (or NAK), then release the pin.
module sw_half_duplex_responder
  import sw_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned TURNAROUND   = 2,
  parameter logic [7:0]  NAK_BYTE     = 8'h15
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  input  logic pin_i,
  output logic pin_o,
  output logic pin_t,
  output logic busy,
  sw_half_duplex_responder_if.slave usr
);

  localparam int unsigned   TW      = $clog2(TURNAROUND * CLKS_PER_BIT);
  localparam int unsigned   BW      = $clog2(FRAME_BITS);
  localparam logic [TW-1:0] LD_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] LD_BIT  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] LD_TURN = TW'(TURNAROUND * CLKS_PER_BIT - 1);

  sw_state_t       state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic            prev_q, prev_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_err_q, rx_err_d;
  logic            stop_err_q, stop_err_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            hold_full_q, hold_full_d;
  logic [7:0]      hold_data_q, hold_data_d;
  logic            pin_t_q, pin_t_d;
  logic            pin_o_q, pin_o_d;
  logic            tmr_load, tmr_done;
  logic [TW-1:0]   tmr_val;
  logic            sync_lvl, fall;

  assign sync_lvl = sync_q[1];
  assign fall     = prev_q & ~sync_lvl;

  sw_bit_timer #(.W(TW)) u_timer (
    .clk      (clk_100MHz),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], pin_i};
    prev_d      = sync_lvl;
    bit_cnt_d   = bit_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_err_d    = 1'b0;
    stop_err_d  = stop_err_q;
    tx_shift_d  = tx_shift_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    tmr_load    = 1'b0;
    tmr_val     = LD_BIT;
    pin_t_d     = PIN_RELEASE;
    pin_o_d     = 1'b1;

    if (usr.resp_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = usr.resp_data;
    end

    unique case (state_q)
      IDLE: if (fall) begin
        state_d  = RX_START;
        tmr_load = 1'b1;
        tmr_val  = LD_HALF;
      end
      RX_START: if (tmr_done) begin
        if (sync_lvl) state_d = IDLE;
        else begin
          state_d   = RX_DATA;
          bit_cnt_d = '0;
          tmr_load  = 1'b1;
        end
      end
      RX_DATA: if (tmr_done) begin
        rx_data_d = {sync_lvl, rx_data_q[7:1]};
        tmr_load  = 1'b1;
        if (bit_cnt_q == BW'(FRAME_BITS - 1)) state_d = RX_STOP;
        else bit_cnt_d = bit_cnt_q + BW'(1);
      end
      // After a framing error the timer is idle; stop_err_q parks the FSM here
      // until the line returns high so the bad frame's tail is not re-received.
      RX_STOP: begin
        if (stop_err_q) begin
          if (sync_lvl) begin
            stop_err_d = 1'b0;
            state_d    = IDLE;
          end
        end else if (tmr_done) begin
          if (sync_lvl) begin
            rx_valid_d = 1'b1;
            state_d    = TURN;
            tmr_load   = 1'b1;
            tmr_val    = LD_TURN;
          end else begin
            rx_err_d   = 1'b1;
            stop_err_d = 1'b1;
          end
        end
      end
      TURN: if (tmr_done) begin
        if (hold_full_q) begin
          tx_shift_d  = hold_data_q;
          hold_full_d = 1'b0;
        end else begin
          tx_shift_d  = NAK_BYTE;
        end
        bit_cnt_d = '0;
        state_d   = TX_START;
        tmr_load  = 1'b1;
      end
      TX_START: if (tmr_done) begin
        state_d  = TX_DATA;
        tmr_load = 1'b1;
      end
      TX_DATA: if (tmr_done) begin
        tmr_load = 1'b1;
        if (bit_cnt_q == BW'(FRAME_BITS - 1)) state_d = TX_STOP;
        else begin
          bit_cnt_d  = bit_cnt_q + BW'(1);
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      TX_STOP: if (tmr_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin outputs follow the next state so they are registered in step with it.
    unique case (state_d)
      TX_START: begin pin_t_d = PIN_DRIVE; pin_o_d = 1'b0;          end
      TX_DATA:  begin pin_t_d = PIN_DRIVE; pin_o_d = tx_shift_d[0]; end
      TX_STOP:  begin pin_t_d = PIN_DRIVE; pin_o_d = 1'b1;          end
      default:  ;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '1;
      prev_q      <= 1'b1;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      stop_err_q  <= 1'b0;
      tx_shift_q  <= '1;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      pin_t_q     <= PIN_RELEASE;
      pin_o_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_err_q    <= rx_err_d;
      stop_err_q  <= stop_err_d;
      tx_shift_q  <= tx_shift_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      pin_t_q     <= pin_t_d;
      pin_o_q     <= pin_o_d;
    end
  end

  assign pin_t          = pin_t_q;
  assign pin_o          = pin_o_q;
  assign busy           = (state_q != IDLE);
  assign usr.rx_data    = rx_data_q;
  assign usr.rx_valid   = rx_valid_q;
  assign usr.rx_err     = rx_err_q;
  assign usr.resp_ready = !hold_full_q;

endmodule

// File: tb/tb_sw_half_duplex_responder.sv
// Bench for sw_half_duplex_responder: initiator model on a pulled-up line,
// frame-level reference model of the response slot, table plus random frames.
module tb_sw_half_duplex_responder;
  import sw_pkg::*;

  localparam int unsigned CPB = 8;
  localparam int unsigned TA  = 2;
  localparam logic [7:0]  NAK = 8'h15;

  typedef struct {
    logic       load;
    logic [7:0] resp;
    logic [7:0] rx;
    logic       good;
    logic [7:0] exp_tx;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic init_oe, init_o;
  logic pin_i, pin_o, pin_t, busy;

  sw_half_duplex_responder_if usr();

  sw_half_duplex_responder #(
    .CLKS_PER_BIT (CPB),
    .TURNAROUND   (TA),
    .NAK_BYTE     (NAK)
  ) dut (
    .clk_100MHz (clk),
    .rst_n      (rst_n),
    .pin_i      (pin_i),
    .pin_o      (pin_o),
    .pin_t      (pin_t),
    .busy       (busy),
    .usr        (usr)
  );

  // IOBUF with pull-up: responder drive wins, else initiator, else high.
  assign pin_i = (pin_t == PIN_DRIVE) ? pin_o : (init_oe ? init_o : 1'b1);

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         vcnt = 0, ecnt = 0, drive_cnt = 0;
  logic [7:0] last_rx = '0;
  bit         have = 1'b0;
  logic [7:0] held = '0;
  vec_t       vecs[6];

  always @(negedge clk) begin
    if (usr.rx_valid) begin
      vcnt    <= vcnt + 1;
      last_rx <= usr.rx_data;
    end
    if (usr.rx_err) ecnt <= ecnt + 1;
    if (pin_t == PIN_DRIVE) drive_cnt <= drive_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic offer(input logic [7:0] b);
    @(negedge clk);
    chk("resp_ready_vs_model", 32'(usr.resp_ready), 32'(!have));
    usr.resp_valid = 1'b1;
    usr.resp_data  = b;
    if (!have) begin
      have = 1'b1;
      held = b;
    end
    @(negedge clk);
    usr.resp_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good);
    logic [9:0] fr;
    fr = {good, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      init_oe = 1'b1;
      init_o  = fr[i];
      repeat (CPB - 1) @(negedge clk);
    end
    if (!good) repeat (2 * CPB) @(negedge clk);
    @(negedge clk);
    init_oe = 1'b0;
    init_o  = 1'b1;
  endtask

  task automatic watch_tx(input logic [7:0] exp, input bit b2b);
    int         n;
    int         idx;
    bit         seen;
    logic [9:0] fr;
    seen = 1'b0;
    for (int i = 0; i < int'(20 * CPB); i++) begin
      @(negedge clk);
      if (usr.rx_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rx_valid_seen", 32'(seen), 32'(1));
    if (!seen) return;
    n = 0;
    while (pin_t && n < int'(4 * TA * CPB)) begin
      n++;
      @(negedge clk);
    end
    chk("turnaround_clks", n, TA * CPB);
    n  = 0;
    fr = '1;
    while (!pin_t && n < int'(20 * CPB)) begin
      if (b2b && n == 0) chk("b2b_ready_after_consume", 32'(usr.resp_ready), 32'(1));
      if (b2b && n == 1) chk("b2b_second_accepted", 32'(usr.resp_ready), 32'(0));
      idx = n / int'(CPB);
      if ((n % int'(CPB)) == int'(CPB / 2) && idx < 10) fr[idx] = pin_i;
      n++;
      @(negedge clk);
    end
    chk("tx_drive_clks", n, 10 * CPB);
    chk("tx_frame", 32'(fr), 32'({1'b1, exp, 1'b0}));
  endtask

  task automatic run_frame(input logic [7:0] rx, input logic good, input logic [7:0] exp, input bit b2b);
    int v0, e0, d0;
    bit idle;
    v0 = vcnt; e0 = ecnt; d0 = drive_cnt;
    if (good) begin
      fork
        send_frame(rx, 1'b1);
        watch_tx(exp, b2b);
      join
      chk("rx_valid_pulses", vcnt - v0, 1);
      chk("rx_data", 32'(last_rx), 32'(rx));
      chk("no_rx_err", ecnt - e0, 0);
      chk("idle_after_tx", 32'(busy), 32'(0));
    end else begin
      send_frame(rx, 1'b0);
      chk("rx_err_pulses", ecnt - e0, 1);
      chk("no_rx_valid_on_err", vcnt - v0, 0);
      chk("no_drive_on_err", drive_cnt - d0, 0);
      chk("err_busy_while_low", 32'(busy), 32'(1));
      idle = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (!busy) begin
          idle = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("err_idle_after_high", 32'(idle), 32'(1));
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         v0, e0;
    bit         seen;
    logic [7:0] rx, exp;
    logic       good;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 1'b1, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 1'b1, NAK};
    vecs[2] = '{1'b1, 8'h7E, 8'h5A, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 8'h00, 8'h81, 1'b1, 8'h7E};
    vecs[4] = '{1'b1, 8'h00, 8'hFF, 1'b1, 8'h00};
    vecs[5] = '{1'b0, 8'h00, 8'hC3, 1'b1, NAK};

    rst_n = 1'b0; init_oe = 1'b0; init_o = 1'b1;
    usr.resp_valid = 1'b0; usr.resp_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_pin_t", 32'(pin_t), 32'(1));
    chk("rst_pin_o", 32'(pin_o), 32'(1));
    chk("rst_resp_ready", 32'(usr.resp_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rx_valid", 32'(usr.rx_valid), 32'(0));
    chk("rst_rx_err", 32'(usr.rx_err), 32'(0));
    chk("rst_rx_data", 32'(usr.rx_data), 32'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].load) offer(vecs[i].resp);
      run_frame(vecs[i].rx, vecs[i].good, vecs[i].exp_tx, 1'b0);
      if (vecs[i].good) have = 1'b0;
    end

    // Short low glitch on an idle line.
    v0 = vcnt; e0 = ecnt; seen = 1'b0;
    @(negedge clk);
    init_oe = 1'b1; init_o = 1'b0;
    repeat (3) @(negedge clk);
    init_oe = 1'b0; init_o = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (busy) seen = 1'b1;
      @(negedge clk);
    end
    chk("glitch_busy_seen", 32'(seen), 32'(1));
    chk("glitch_back_idle", 32'(busy), 32'(0));
    chk("glitch_no_valid", vcnt - v0, 0);
    chk("glitch_no_err", ecnt - e0, 0);

    // Back-to-back offers: second byte waits for the slot to free at TURN.
    @(negedge clk);
    chk("b2b_ready_first", 32'(usr.resp_ready), 32'(1));
    usr.resp_valid = 1'b1; usr.resp_data = 8'h11;
    @(negedge clk);
    chk("b2b_ready_low_when_full", 32'(usr.resp_ready), 32'(0));
    usr.resp_data = 8'h22;
    run_frame(8'h6B, 1'b1, 8'h11, 1'b1);
    usr.resp_valid = 1'b0;
    have = 1'b1; held = 8'h22;
    run_frame(8'h99, 1'b1, 8'h22, 1'b0);
    have = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) offer(8'($urandom));
      rx   = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      exp  = have ? held : NAK;
      run_frame(rx, good, exp, 1'b0);
      if (good) have = 1'b0;
    end

    // Reset asserted mid-TX must release the pin without a clock edge.
    send_frame(8'h42, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < int'(8 * CPB); i++) begin
      @(negedge clk);
      if (!pin_t) begin
        seen = 1'b1;
        break;
      end
    end
    chk("mid_tx_driving", 32'(seen), 32'(1));
    repeat (CPB + 2) @(negedge clk);
    chk("mid_tx_still_driving", 32'(pin_t), 32'(0));
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_pin_t", 32'(pin_t), 32'(1));
    chk("async_rst_pin_o", 32'(pin_o), 32'(1));
    chk("async_rst_busy", 32'(busy), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    have  = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", 32'(usr.resp_ready), 32'(1));
    chk("post_rst_idle", 32'(busy), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
